keccak_msg_packer: RTL and testbench
====================================

Name: keccak_msg_packer

Overview:
Transmit-side front end for the keccak core's 32-bit word input interface. It accepts a message as a byte stream and packs it big-endian into 32-bit words. It drives in/in_ready/is_last/byte_num to the core under buffer_full back-pressure, including the zero tail word required when the message length is a multiple of 4. After the digest is reported it pulses the core's restart so the next message can begin.

Parameters:
RESTART_CYCLES, 1, cycles core_restart is held high after digest_ready (1..15)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-low (0 = reset)
byte_in  in  8  message byte
byte_valid  in  1  byte_in valid
byte_last  in  1  qualifies final byte of message (with byte_valid)
byte_ready  out  1  packer can accept a byte this cycle
word_out  out  32  to core `in`
word_ready  out  1  to core `in_ready`
word_is_last  out  1  to core `is_last`
word_byte_num  out  2  to core `byte_num`
buffer_full  in  1  from core; word not taken while high
digest_ready  in  1  from core `out_ready`
core_restart  out  1  to core reset (active-high pulse)
busy  out  1  message in flight (not FILL with cnt==0)

Behaviour:
- Reset (reset==0 at posedge): state=FILL, cnt=0, acc=0, tail_pending=0, final_word=0, core_restart=0, restart counter=0, all word_* outputs=0, byte_ready=1 on the next cycle, busy=0.
- Byte accept: byte_valid && byte_ready at posedge. Byte i of a word goes to acc[31-8i -: 8] (first byte in [31:24]). Unused lanes are 0.
- States: FILL, EMIT, EMIT_TAIL, WAIT_DIGEST, RESTART.
- FILL: byte_ready=1, word_ready=0.
  - Accept with cnt<3 and !byte_last: cnt++.
  - Accept with cnt==3 and !byte_last: latch full word, is_last=0, byte_num=0, go EMIT, cnt=0.
  - Accept with byte_last and cnt<3: latch word, is_last=1, byte_num=cnt+1, final_word=1, go EMIT.
  - Accept with byte_last and cnt==3: latch full word, is_last=0, tail_pending=1, go EMIT.
- EMIT: word_ready=1, byte_ready=0. word_out/is_last/byte_num stay stable while buffer_full=1. Transfer occurs at a posedge with buffer_full=0. Next state:
  - tail_pending: go EMIT_TAIL.
  - final_word: go WAIT_DIGEST.
  - otherwise: go FILL with acc cleared.
- EMIT_TAIL: word_out=0, word_byte_num=0, word_is_last=1, word_ready=1. Held under buffer_full. On transfer, go WAIT_DIGEST.
- WAIT_DIGEST: word_ready=0, byte_ready=0. digest_ready=1 moves to RESTART.
- RESTART: core_restart=1 for exactly RESTART_CYCLES cycles, then go FILL with all flags cleared.
- digest_ready outside WAIT_DIGEST is ignored.
- Latency: a completing byte is accepted at edge N, and word_ready=1 from cycle N+1. With no stall, the minimum is 5 cycles per word.
- word_is_last is never asserted with word_ready=0. Exactly one is_last word per message.
- Reset asserted mid-operation, in any state, aborts immediately. A half-filled acc is discarded; no is_last is emitted.
- Zero-length messages are unsupported: byte_last always qualifies a real byte.

Decomposition:
- Package keccak_pkg holds:
  - WORD_W=32, BYTES_PER_WORD=4;
  - the packer state enum {FILL, EMIT, EMIT_TAIL, WAIT_DIGEST, RESTART}.
- No sub-module is needed. The byte accumulator and FSM are a single always block each.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) -> one word 0x61626300, byte_num=3, is_last=1; then WAIT_DIGEST.
- "abcd" -> word 0x61626364 is_last=0, then word 0x00000000 byte_num=0 is_last=1.
- "Hello, wo" (9 bytes) -> 0x48656C6C, 0x6F2C2077, 0x6F000000 with byte_num=1, is_last=1.
- buffer_full=1 for 3 cycles during EMIT -> word_ready and word_out stay constant for 4 cycles; exactly one transfer; byte_ready=0 throughout.
- digest_ready pulse in WAIT_DIGEST with RESTART_CYCLES=2 -> core_restart high for 2 cycles, then byte_ready=1, busy=0. A digest_ready pulse during FILL produces no restart.
- reset=0 after 2 bytes of a word -> next cycle cnt=0, word_ready=0, no is_last ever. A following "abc" yields 0x61626300.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the keccak message packer.
package keccak_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    FILL,
    EMIT,
    EMIT_TAIL,
    WAIT_DIGEST,
    RESTART
  } pk_state_e;

endpackage

// File: rtl/keccak_msg_packer.sv
// Packs a byte stream big-endian into 32-bit words for the keccak core,
// appends the zero tail word on word-aligned messages and pulses core restart.
module keccak_msg_packer
  import keccak_pkg::*;
#(
  parameter int unsigned RESTART_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_ready,
  output logic              word_is_last,
  output logic [1:0]        word_byte_num,
  input  logic              buffer_full,
  input  logic              digest_ready,
  output logic              core_restart,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES_PER_WORD - 1);

  pk_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic              tail_q, tail_d;
  logic              final_q, final_d;
  logic              last_q, last_d;
  logic [1:0]        bnum_q, bnum_d;
  logic [3:0]        rcnt_q, rcnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
      tail_q  <= 1'b0;
      final_q <= 1'b0;
      last_q  <= 1'b0;
      bnum_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      tail_q  <= tail_d;
      final_q <= final_d;
      last_q  <= last_d;
      bnum_q  <= bnum_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    tail_d  = tail_q;
    final_d = final_q;
    last_d  = last_q;
    bnum_d  = bnum_q;
    rcnt_d  = rcnt_q;

    byte_ready    = 1'b0;
    word_out      = '0;
    word_ready    = 1'b0;
    word_is_last  = 1'b0;
    word_byte_num = '0;
    core_restart  = 1'b0;

    unique case (state_q)
      FILL: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          // acc doubles as the outgoing word register while in EMIT
          acc_d[WORD_W-1-8*cnt_q -: 8] = byte_in;
          if (byte_last) begin
            state_d = EMIT;
            cnt_d   = '0;
            if (cnt_q == LAST_LANE) begin
              last_d = 1'b0;
              bnum_d = '0;
              tail_d = 1'b1;
            end else begin
              last_d  = 1'b1;
              bnum_d  = cnt_q + CNT_W'(1);
              final_d = 1'b1;
            end
          end else if (cnt_q == LAST_LANE) begin
            state_d = EMIT;
            cnt_d   = '0;
            last_d  = 1'b0;
            bnum_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      EMIT: begin
        word_ready    = 1'b1;
        word_out      = acc_q;
        word_is_last  = last_q;
        word_byte_num = bnum_q;
        if (!buffer_full) begin
          if (tail_q) begin
            state_d = EMIT_TAIL;
          end else if (final_q) begin
            state_d = WAIT_DIGEST;
          end else begin
            state_d = FILL;
            acc_d   = '0;
          end
        end
      end

      EMIT_TAIL: begin
        word_ready   = 1'b1;
        word_is_last = 1'b1;
        if (!buffer_full) state_d = WAIT_DIGEST;
      end

      WAIT_DIGEST: begin
        if (digest_ready) begin
          state_d = RESTART;
          rcnt_d  = '0;
        end
      end

      RESTART: begin
        core_restart = 1'b1;
        if (rcnt_q == 4'(RESTART_CYCLES - 1)) begin
          state_d = FILL;
          cnt_d   = '0;
          acc_d   = '0;
          tail_d  = 1'b0;
          final_d = 1'b0;
          last_d  = 1'b0;
          bnum_d  = '0;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end

      default: state_d = FILL;
    endcase
  end

  assign busy = !((state_q == FILL) && (cnt_q == '0));

endmodule

// File: tb/tb_keccak_msg_packer.sv
// Self-checking bench: byte messages are driven in, transferred words are
// captured and compared with a per-message model of the expected word list.
module tb_keccak_msg_packer;

  localparam int unsigned RC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic [31:0] word_out;
  logic        word_ready;
  logic        word_is_last;
  logic [1:0]  word_byte_num;
  logic        buffer_full;
  logic        digest_ready;
  logic        core_restart;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int last_viol = 0;
  int bf_mode = 0;  // 0: never full, 1: random stalls, 2: driven by the test

  logic [34:0] got_q[$];
  logic [34:0] exp_q[$];

  keccak_msg_packer #(.RESTART_CYCLES(RC)) dut (
    .clk(clk), .reset(reset),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
    .byte_ready(byte_ready),
    .word_out(word_out), .word_ready(word_ready),
    .word_is_last(word_is_last), .word_byte_num(word_byte_num),
    .buffer_full(buffer_full), .digest_ready(digest_ready),
    .core_restart(core_restart), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (word_ready && !buffer_full)
      got_q.push_back({word_out, word_is_last, word_byte_num});
    if (word_is_last && !word_ready)
      last_viol <= last_viol + 1;
  end

  initial begin
    buffer_full = 1'b0;
    forever begin
      @(negedge clk);
      if (bf_mode == 1) buffer_full = ($urandom_range(0, 2) == 0);
      else if (bf_mode == 0) buffer_full = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected transfers for a whole message: zero-padded big-endian words,
  // plus a separate all-zero last word when the length is a multiple of 4.
  function automatic void build_expected(input logic [7:0] m[$]);
    int n;
    int nw;
    logic [31:0] w;
    logic        lst;
    logic [1:0]  bn;
    exp_q.delete();
    n  = m.size();
    nw = (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        w = {w[23:0], ((4 * k + b) < n) ? m[4 * k + b] : 8'h00};
      lst = (k == nw - 1) && (n % 4 != 0);
      bn  = lst ? 2'(n % 4) : 2'd0;
      exp_q.push_back({w, lst, bn});
    end
    if (n % 4 == 0) exp_q.push_back({32'h0, 1'b1, 2'd0});
  endfunction

  task automatic send_msg(input logic [7:0] m[$], input bit mark_last);
    for (int i = 0; i < m.size(); i++) begin
      int t;
      t = 0;
      @(negedge clk);
      byte_in    = m[i];
      byte_valid = 1'b1;
      byte_last  = mark_last && (i == m.size() - 1);
      while (!byte_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0d not accepted, byte_ready=%b required 1", i, byte_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic expect_words(input string name);
    int t;
    int n;
    t = 0;
    while ((got_q.size() < exp_q.size() || word_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 500) begin
      errors++;
      $display("FAIL %s word_timeout: got %0d words, required %0d", name, got_q.size(), exp_q.size());
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s word_count: got %0d, required %0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s word%0d: got %h last=%b bn=%0d, required %h last=%b bn=%0d",
                 name, i, got_q[i][34:3], got_q[i][2], got_q[i][1:0],
                 exp_q[i][34:3], exp_q[i][2], exp_q[i][1:0]);
      end
    end
    checks++;
    if (last_viol !== 0) begin
      errors++;
      $display("FAIL %s is_last_without_ready: got %0d occurrences, required 0", name, last_viol);
    end
    got_q.delete();
  endtask

  task automatic do_digest(input string name);
    int cnt;
    repeat (3) @(negedge clk);
    checks++;
    if (word_ready !== 1'b0 || byte_ready !== 1'b0 || busy !== 1'b1 || core_restart !== 1'b0) begin
      errors++;
      $display("FAIL %s wait_digest: got wr=%b br=%b busy=%b rst=%b, required 0 0 1 0",
               name, word_ready, byte_ready, busy, core_restart);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    cnt = 0;
    while (core_restart && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt !== RC) begin
      errors++;
      $display("FAIL %s restart_len: got %0d cycles, required %0d", name, cnt, RC);
    end
    checks++;
    if (byte_ready !== 1'b1 || busy !== 1'b0 || word_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s after_restart: got br=%b busy=%b wr=%b, required 1 0 0",
               name, byte_ready, busy, word_ready);
    end
  endtask

  task automatic run_msg(input string name, input logic [7:0] m[$]);
    build_expected(m);
    got_q.delete();
    send_msg(m, 1'b1);
    expect_words(name);
    do_digest(name);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1) begin errors++; $display("FAIL reset byte_ready: got %b required 1", byte_ready); end
    checks++;
    if (word_ready !== 1'b0) begin errors++; $display("FAIL reset word_ready: got %b required 0", word_ready); end
    checks++;
    if (word_out !== 32'h0) begin errors++; $display("FAIL reset word_out: got %h required 0", word_out); end
    checks++;
    if (word_is_last !== 1'b0 || word_byte_num !== 2'd0) begin
      errors++; $display("FAIL reset last/bn: got %b/%0d required 0/0", word_is_last, word_byte_num);
    end
    checks++;
    if (core_restart !== 1'b0) begin errors++; $display("FAIL reset core_restart: got %b required 0", core_restart); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
  endtask

  task automatic test_abc();
    run_msg("abc", '{8'h61, 8'h62, 8'h63});
  endtask

  task automatic test_abcd();
    run_msg("abcd", '{8'h61, 8'h62, 8'h63, 8'h64});
  endtask

  task automatic test_hello();
    run_msg("hello", '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h77, 8'h6F});
  endtask

  task automatic test_stall();
    logic [7:0] m[$];
    m = '{8'h61, 8'h62, 8'h63};
    build_expected(m);
    got_q.delete();
    bf_mode = 2;
    buffer_full = 1'b1;
    send_msg(m, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (word_ready !== 1'b1 || word_out !== 32'h61626300 || byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall cycle%0d: got wr=%b out=%h br=%b, required 1 61626300 0",
                 i, word_ready, word_out, byte_ready);
      end
      if (i == 3) buffer_full = 1'b0;
      @(negedge clk);
    end
    bf_mode = 0;
    expect_words("stall");
    do_digest("stall");
  endtask

  task automatic test_digest_ignored();
    @(negedge clk);
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (core_restart !== 1'b0 || byte_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL digest_ignored cycle%0d: got rst=%b br=%b busy=%b, required 0 1 0",
                 i, core_restart, byte_ready, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    got_q.delete();
    send_msg('{8'h11, 8'h22}, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort pre_busy: got %b required 1", busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || word_ready !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort state: got busy=%b wr=%b br=%b, required 0 0 1", busy, word_ready, byte_ready);
    end
    reset = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (got_q.size() !== 0) begin
      errors++;
      $display("FAIL abort no_words: got %0d transfers, required 0", got_q.size());
    end
    run_msg("abort_abc", '{8'h61, 8'h62, 8'h63});
  endtask

  task automatic test_random();
    logic [7:0] m[$];
    bf_mode = 1;
    for (int k = 0; k < 8; k++) begin
      int len;
      len = $urandom_range(1, 13);
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      run_msg($sformatf("random%0d_len%0d", k, len), m);
    end
    bf_mode = 0;
  endtask

  initial begin
    reset        = 1'b0;
    byte_in      = 8'h00;
    byte_valid   = 1'b0;
    byte_last    = 1'b0;
    digest_ready = 1'b0;
    test_reset();
    test_abc();
    test_abcd();
    test_hello();
    test_stall();
    test_digest_ignored();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
